regfile_fwd_sb: RTL and testbench

Parametrised register file for the MIPS datapath's decode stage. It has two synchronous read ports and one write port. Operand forwarding from the EX, DM and WB stages is resolved internally by destination-address compare, replacing externally driven mux selects. A per-register pending-write scoreboard raises `stall` when a source operand's producing load has not yet returned. The operand outputs feed the ALU directly, with an immediate override on operand B.

---
 rtl/mips_pkg.sv | 16 +
 rtl/regfile_fwd_sb_if.sv | 50 +++++
 rtl/regfile_fwd_sb_fwd_sel.sv | 47 ++++
 rtl/regfile_fwd_sb.sv | 133 +++++++++++++
 tb/tb_regfile_fwd_sb.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, forwarding-source enum and zero-register constant
package mips_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 5;
  localparam int ZERO_ADDR  = 0;

  // Which source an operand was taken from this cycle
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_EX  = 2'd1,
    FWD_DM  = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

endpackage

// File: rtl/regfile_fwd_sb_if.sv
// rtl/regfile_fwd_sb_if.sv - decode-side bus of the forwarding register file
interface regfile_fwd_sb_if #(
  parameter int DATA_W = mips_pkg::DATA_W_DEF,
  parameter int ADDR_W = mips_pkg::ADDR_W_DEF
);
  import mips_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic                rd_en;
  logic [ADDR_W-1:0]   ra;
  logic [ADDR_W-1:0]   rb;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic                ex_vld;
  logic [ADDR_W-1:0]   ex_rd;
  logic [DATA_W-1:0]   ex_ans;
  logic                dm_vld;
  logic [ADDR_W-1:0]   dm_rd;
  logic [DATA_W-1:0]   dm_ans;
  logic                wb_vld;
  logic [ADDR_W-1:0]   wb_rd;
  logic [DATA_W-1:0]   wb_ans;
  logic                ld_issue;
  logic [ADDR_W-1:0]   ld_rd;
  logic                imm_sel;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   a;
  logic [DATA_W-1:0]   b;
  logic                stall;
  logic [NUM_REGS-1:0] pending;
  fwd_sel_t            a_src;
  fwd_sel_t            b_src;

  modport master (
    output rd_en, ra, rb, wr_en, wr_addr, wr_data,
    output ex_vld, ex_rd, ex_ans, dm_vld, dm_rd, dm_ans, wb_vld, wb_rd, wb_ans,
    output ld_issue, ld_rd, imm_sel, imm,
    input  a, b, stall, pending, a_src, b_src
  );

  modport slave (
    input  rd_en, ra, rb, wr_en, wr_addr, wr_data,
    input  ex_vld, ex_rd, ex_ans, dm_vld, dm_rd, dm_ans, wb_vld, wb_rd, wb_ans,
    input  ld_issue, ld_rd, imm_sel, imm,
    output a, b, stall, pending, a_src, b_src
  );

endinterface

// File: rtl/regfile_fwd_sb_fwd_sel.sv
// rtl/regfile_fwd_sb_fwd_sel.sv - per-operand EX/DM/WB address compare and priority mux
module fwd_sel
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  input  logic              i_ex_vld,
  input  logic [ADDR_W-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_ans,
  input  logic              i_dm_vld,
  input  logic [ADDR_W-1:0] i_dm_rd,
  input  logic [DATA_W-1:0] i_dm_ans,
  input  logic              i_wb_vld,
  input  logic [ADDR_W-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_ans,
  output logic [DATA_W-1:0] o_data,
  output fwd_sel_t          o_sel
);

  logic w_zero;

  // A hardwired-zero source never matches, so dest 0 can never forward
  assign w_zero = ZERO_REG && (i_addr == ADDR_W'(ZERO_ADDR));

  // Youngest producer wins: EX, then DM, then WB, then the captured array value
  always_comb begin
    o_data = i_reg_data;
    o_sel  = FWD_REG;
    if (w_zero) begin
      o_data = '0;
    end else if (i_ex_vld && (i_ex_rd == i_addr)) begin
      o_data = i_ex_ans;
      o_sel  = FWD_EX;
    end else if (i_dm_vld && (i_dm_rd == i_addr)) begin
      o_data = i_dm_ans;
      o_sel  = FWD_DM;
    end else if (i_wb_vld && (i_wb_rd == i_addr)) begin
      o_data = i_wb_ans;
      o_sel  = FWD_WB;
    end
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// rtl/regfile_fwd_sb.sv - decode register file with internal forwarding and load scoreboard
module regfile_fwd_sb
  import mips_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input logic             clk,
  input logic             rst_n,
  regfile_fwd_sb_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZADDR = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [ADDR_W-1:0]   r_ra_q;
  logic [ADDR_W-1:0]   r_rb_q;
  logic [DATA_W-1:0]   r_ar_q;
  logic [DATA_W-1:0]   r_br_q;
  logic [NUM_REGS-1:0] r_pending;

  logic                w_wr_ok;
  logic                w_ld_set;
  logic                w_dm_clr;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_pend_eff;
  logic                w_stall;
  logic                w_capture;
  logic [DATA_W-1:0]   w_ra_data;
  logic [DATA_W-1:0]   w_rb_data;
  logic [DATA_W-1:0]   w_a_fwd;
  logic [DATA_W-1:0]   w_b_fwd;
  fwd_sel_t            w_a_src;
  fwd_sel_t            w_b_src;

  assign w_wr_ok  = bus.wr_en    && !(ZERO_REG && (bus.wr_addr == ZADDR));
  assign w_ld_set = bus.ld_issue && !(ZERO_REG && (bus.ld_rd   == ZADDR));
  assign w_dm_clr = bus.dm_vld   && !(ZERO_REG && (bus.dm_rd   == ZADDR));

  // One-hot set/clear requests for the scoreboard this cycle
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    if (w_ld_set) w_set_vec[bus.ld_rd] = 1'b1;
    if (w_dm_clr) w_clr_vec[bus.dm_rd] = 1'b1;
  end

  // A load returning through DM this cycle is forwardable, so it no longer blocks
  assign w_pend_eff = r_pending & ~w_clr_vec;
  assign w_stall    = bus.rd_en &
                      (w_pend_eff[bus.ra] | (w_pend_eff[bus.rb] & ~bus.imm_sel));
  assign w_capture  = bus.rd_en & ~w_stall;

  // Write-through so a same-cycle write is seen by the read being captured
  assign w_ra_data = (w_wr_ok && (bus.wr_addr == bus.ra)) ? bus.wr_data : r_mem[bus.ra];
  assign w_rb_data = (w_wr_ok && (bus.wr_addr == bus.rb)) ? bus.wr_data : r_mem[bus.rb];

  // Architectural register array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read stage: capture addresses and data unless stalled or idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra_q <= '0;
      r_rb_q <= '0;
      r_ar_q <= '0;
      r_br_q <= '0;
    end else if (w_capture) begin
      r_ra_q <= bus.ra;
      r_rb_q <= bus.rb;
      r_ar_q <= w_ra_data;
      r_br_q <= w_rb_data;
    end
  end

  // Pending-load scoreboard; a new load outranks a same-cycle return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
    end
  end

  fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .i_addr     (r_ra_q),
    .i_reg_data (r_ar_q),
    .i_ex_vld   (bus.ex_vld),
    .i_ex_rd    (bus.ex_rd),
    .i_ex_ans   (bus.ex_ans),
    .i_dm_vld   (bus.dm_vld),
    .i_dm_rd    (bus.dm_rd),
    .i_dm_ans   (bus.dm_ans),
    .i_wb_vld   (bus.wb_vld),
    .i_wb_rd    (bus.wb_rd),
    .i_wb_ans   (bus.wb_ans),
    .o_data     (w_a_fwd),
    .o_sel      (w_a_src)
  );

  fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .i_addr     (r_rb_q),
    .i_reg_data (r_br_q),
    .i_ex_vld   (bus.ex_vld),
    .i_ex_rd    (bus.ex_rd),
    .i_ex_ans   (bus.ex_ans),
    .i_dm_vld   (bus.dm_vld),
    .i_dm_rd    (bus.dm_rd),
    .i_dm_ans   (bus.dm_ans),
    .i_wb_vld   (bus.wb_vld),
    .i_wb_rd    (bus.wb_rd),
    .i_wb_ans   (bus.wb_ans),
    .o_data     (w_b_fwd),
    .o_sel      (w_b_src)
  );

  assign bus.a       = w_a_fwd;
  assign bus.b       = bus.imm_sel ? bus.imm : w_b_fwd;
  assign bus.stall   = w_stall;
  assign bus.pending = r_pending;
  assign bus.a_src   = w_a_src;
  assign bus.b_src   = w_b_src;

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// tb/tb_regfile_fwd_sb.sv - directed vector bench for regfile_fwd_sb
module tb_regfile_fwd_sb;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  regfile_fwd_sb_if #(.DATA_W(16), .ADDR_W(5)) bus ();

  regfile_fwd_sb #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        rd_en;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        imm_sel;
    logic [15:0] imm;
    logic        ex_vld;
    logic [4:0]  ex_rd;
    logic [15:0] ex_ans;
    logic        dm_vld;
    logic [4:0]  dm_rd;
    logic [15:0] dm_ans;
    logic        wb_vld;
    logic [4:0]  wb_rd;
    logic [15:0] wb_ans;
    logic        exp_stall;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vt [10];

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                              input logic re, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [15:0] ea, input logic [15:0] eb);
    vec_t v;
    v         = '0;
    v.wr_en   = we;
    v.wr_addr = wa;
    v.wr_data = wd;
    v.rd_en   = re;
    v.ra      = ra;
    v.rb      = rb;
    v.exp_a   = ea;
    v.exp_b   = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    bus.rd_en = 0; bus.ra = 0; bus.rb = 0;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
    bus.ex_vld = 0; bus.ex_rd = 0; bus.ex_ans = 0;
    bus.dm_vld = 0; bus.dm_rd = 0; bus.dm_ans = 0;
    bus.wb_vld = 0; bus.wb_rd = 0; bus.wb_ans = 0;
    bus.ld_issue = 0; bus.ld_rd = 0;
    bus.imm_sel = 0; bus.imm = 0;
  endtask

  task automatic apply(input vec_t v);
    bus.wr_en = v.wr_en; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
    bus.rd_en = v.rd_en; bus.ra = v.ra; bus.rb = v.rb;
    bus.imm_sel = v.imm_sel; bus.imm = v.imm;
    bus.ex_vld = v.ex_vld; bus.ex_rd = v.ex_rd; bus.ex_ans = v.ex_ans;
    bus.dm_vld = v.dm_vld; bus.dm_rd = v.dm_rd; bus.dm_ans = v.dm_ans;
    bus.wb_vld = v.wb_vld; bus.wb_rd = v.wb_rd; bus.wb_ans = v.wb_ans;
    bus.ld_issue = 0; bus.ld_rd = 0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vt[0] = mk(1, 5'd3, 16'h1234, 1, 5'd3, 5'd7, 16'h1234, 16'h0000);
    vt[1] = mk(1, 5'd5, 16'h5555, 1, 5'd5, 5'd3, 16'h5555, 16'h1234);
    vt[2] = mk(0, 5'd0, 16'h0000, 1, 5'd5, 5'd3, 16'hAAAA, 16'h1234);
    vt[2].ex_vld = 1; vt[2].ex_rd = 5'd5; vt[2].ex_ans = 16'hAAAA;
    vt[2].dm_vld = 1; vt[2].dm_rd = 5'd5; vt[2].dm_ans = 16'hBBBB;
    vt[2].wb_vld = 1; vt[2].wb_rd = 5'd5; vt[2].wb_ans = 16'hCCCC;
    vt[3] = vt[2]; vt[3].ex_vld = 0; vt[3].exp_a = 16'hBBBB;
    vt[4] = vt[3]; vt[4].dm_vld = 0; vt[4].exp_a = 16'hCCCC;
    vt[5] = mk(0, 5'd0, 16'h0000, 1, 5'd5, 5'd3, 16'h5555, 16'h1234);
    vt[6] = mk(0, 5'd0, 16'h0000, 1, 5'd5, 5'd3, 16'h5555, 16'hBEEF);
    vt[6].imm_sel = 1; vt[6].imm = 16'hBEEF;
    vt[7] = mk(1, 5'd0, 16'hFFFF, 1, 5'd0, 5'd5, 16'h0000, 16'h5555);
    vt[7].ex_vld = 1; vt[7].ex_rd = 5'd0; vt[7].ex_ans = 16'h1111;
    vt[8] = mk(0, 5'd0, 16'h0000, 1, 5'd3, 5'd5, 16'h3333, 16'h7777);
    vt[8].dm_vld = 1; vt[8].dm_rd = 5'd3; vt[8].dm_ans = 16'h3333;
    vt[8].wb_vld = 1; vt[8].wb_rd = 5'd5; vt[8].wb_ans = 16'h7777;
    vt[9] = mk(0, 5'd0, 16'h0000, 0, 5'd7, 5'd7, 16'h1234, 16'h5555);

    // Reset state
    clear_in();
    bus.imm_sel = 1; bus.imm = 16'h1357;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("rst_a", 32'(bus.a), 32'h0);
    chk("rst_b_imm", 32'(bus.b), 32'h1357);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_pending", bus.pending, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    clear_in();

    // Single-cycle vectors
    for (int i = 0; i < 10; i++) begin
      apply(vt[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vt[i].exp_stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_a", i), 32'(bus.a), 32'(vt[i].exp_a));
      chk($sformatf("v%0d_b", i), 32'(bus.b), 32'(vt[i].exp_b));
    end

    // Load-use stall and release by DM return
    clear_in();
    bus.ld_issue = 1; bus.ld_rd = 5'd9;
    @(posedge clk); #1;
    clear_in();
    bus.rd_en = 1; bus.ra = 5'd9; bus.rb = 5'd0;
    #1;
    chk("lu_stall", 32'(bus.stall), 32'h1);
    chk("lu_pend9", 32'(bus.pending[9]), 32'h1);
    @(posedge clk); #1;
    chk("lu_hold_a", 32'(bus.a), 32'h1234);
    chk("lu_still_stall", 32'(bus.stall), 32'h1);
    bus.dm_vld = 1; bus.dm_rd = 5'd9; bus.dm_ans = 16'h0042;
    #1;
    chk("lu_release", 32'(bus.stall), 32'h0);
    @(posedge clk); #1;
    chk("lu_a", 32'(bus.a), 32'h0042);
    chk("lu_a_src", 32'(bus.a_src), 32'(FWD_DM));
    chk("lu_pend9_clr", 32'(bus.pending[9]), 32'h0);

    // Zero register never goes pending
    clear_in();
    bus.ld_issue = 1; bus.ld_rd = 5'd0;
    @(posedge clk); #1;
    clear_in();
    chk("zero_pend", bus.pending, 32'h0);

    // Set/clear collision, then immediate masks B's stall
    bus.ld_issue = 1; bus.ld_rd = 5'd4;
    bus.dm_vld = 1; bus.dm_rd = 5'd4; bus.dm_ans = 16'h0;
    @(posedge clk); #1;
    clear_in();
    chk("coll_pend", bus.pending, 32'h0000_0010);
    bus.rd_en = 1; bus.ra = 5'd3; bus.rb = 5'd4;
    #1;
    chk("coll_stall_b", 32'(bus.stall), 32'h1);
    bus.imm_sel = 1; bus.imm = 16'h0ABC;
    #1;
    chk("coll_imm_nostall", 32'(bus.stall), 32'h0);
    @(posedge clk); #1;
    chk("coll_b_imm", 32'(bus.b), 32'h0ABC);
    chk("coll_a", 32'(bus.a), 32'h1234);

    // Asynchronous reset while stalled
    bus.imm_sel = 0;
    #1;
    chk("ar_pre_stall", 32'(bus.stall), 32'h1);
    #1 rst_n = 0;
    #1;
    chk("ar_pending", bus.pending, 32'h0);
    chk("ar_stall", 32'(bus.stall), 32'h0);
    chk("ar_a", 32'(bus.a), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
